// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, routing header fields and the null address.
package noc_pkg;

    localparam int DATA_W   = 16;
    localparam int HEADER_W = 6;
    localparam int GROUP_W  = 4;
    localparam int LEAF_W   = 2;

    localparam logic [HEADER_W-1:0] NULL_ADDR = '0;

    function automatic logic [HEADER_W-1:0] get_header(input logic [DATA_W-1:0] flit);
        return flit[DATA_W-1 -: HEADER_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i (wrapping) wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] grant_o
);

    logic [PTR_W:0] idx;
    logic           found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N_REQ)) begin
                idx = idx - (PTR_W+1)'(N_REQ);
            end
            if (!found && req_i[idx[PTR_W-1:0]]) begin
                grant_o[idx[PTR_W-1:0]] = en_i;
                found                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/group_uplink_arbiter.sv
// Round-robin uplink sharing for a leaf group, with a single registered output stage.
// Statistics counters are built only when GROUP_ARB_STATS_EN is defined.
module group_uplink_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       up_data_o,
    output logic                    up_valid_o,
    input  logic                    up_ready_i,
    output logic [N_REQ*CNT_W-1:0]  grant_cnt_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              up_valid_q, up_valid_d;
    logic [DATA_W-1:0] up_data_q, up_data_d;
    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_flit;
    logic              slot_free, accept, is_null;

    assign slot_free = !up_valid_q || up_ready_i;

    // Gating with reset keeps ready low while the block is held in reset.
    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (slot_free && reset),
        .grant_o (grant)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_idx = PTR_W'(i);
        end
    end

    assign win_flit = req_data_i[win_idx*DATA_W +: DATA_W];
    assign is_null  = (get_header(win_flit) == NULL_ADDR);

    always_comb begin
        ptr_d      = ptr_q;
        up_valid_d = up_valid_q;
        up_data_d  = up_data_q;
        if (up_valid_q && up_ready_i) up_valid_d = 1'b0;
        if (accept) begin
            ptr_d = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
            if (!is_null) begin
                up_valid_d = 1'b1;
                up_data_d  = win_flit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            up_valid_q <= 1'b0;
            up_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            up_valid_q <= up_valid_d;
            up_data_q  <= up_data_d;
        end
    end

    assign up_valid_o = up_valid_q;
    assign up_data_o  = up_data_q;

`ifdef GROUP_ARB_STATS_EN
    logic [N_REQ-1:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_W-1:0]            drop_cnt_q, drop_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept && (grant_cnt_q[win_idx] != '1)) begin
            grant_cnt_d[win_idx] = grant_cnt_q[win_idx] + 1'b1;
        end
        if (accept && is_null && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`else
    assign grant_cnt_o = '0;
    assign drop_cnt_o  = '0;
`endif

endmodule
